// File: rtl/ysyx_24100006_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_rd_arbiter
// Purpose  : Two-requester AXI read-channel arbiter (IFU / LSU -> xbar).
//            Grants one full read transaction (AR handshake plus all R beats
//            through rlast) at a time, and holds off new grants while a
//            store is outstanding on the write channel.
// Options  : YSYX_24100006_ARB_PERF_EN adds per-requester wait counters
//            (perf_ifu_wait / perf_lsu_wait).
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100006_rd_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // IFU side
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [42:0] ifu_ar,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU side
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [42:0] lsu_ar,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // Shared R payload {rdata, rresp, rlast}
    output logic [34:0] r_payload,
    // Store in flight on the write channel
    input  logic        wr_busy,
    // Bus side
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [42:0] m_ar,
    input  logic        m_rvalid,
    output logic        m_rready,
`ifdef YSYX_24100006_ARB_PERF_EN
    output logic [31:0] perf_ifu_wait,
    output logic [31:0] perf_lsu_wait,
`endif
    input  logic [34:0] m_r
);

    // Streak threshold in the width of the streak counter.
    localparam logic [3:0] STARVE_TH  = 4'(STARVE_LIMIT);
    localparam logic [3:0] STREAK_MAX = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AR_IFU = 3'd1,
        S_AR_LSU = 3'd2,
        S_R_IFU  = 3'd3,
        S_R_LSU  = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] streak;

    logic       grant_ifu;
    logic       grant_lsu;
    logic       r_last_hs;

    // The R payload is a pure broadcast; the per-requester rvalid qualifies it.
    assign r_payload = m_r;

    // Final beat accepted by the granted requester ends the transaction.
    assign r_last_hs = m_rvalid & m_rready & m_r[0];

    // Arbitration decision used only in IDLE: LSU has priority unless the
    // IFU has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!wr_busy) begin
            if (ifu_arvalid && lsu_arvalid) begin
                if (streak >= STARVE_TH) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else if (ifu_arvalid) begin
                grant_ifu = 1'b1;
            end else if (lsu_arvalid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    // Grant state machine and IFU starvation streak counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            streak <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_ifu) begin
                        state  <= S_AR_IFU;
                        streak <= 4'd0;
                    end else if (grant_lsu) begin
                        state <= S_AR_LSU;
                        // Only count LSU wins that actually made the IFU wait.
                        if (ifu_arvalid && (streak != STREAK_MAX)) begin
                            streak <= streak + 4'd1;
                        end
                    end
                end
                S_AR_IFU: begin
                    // A withdrawn request is dropped without touching the bus.
                    if (!ifu_arvalid) begin
                        state <= S_IDLE;
                    end else if (m_arready) begin
                        state <= S_R_IFU;
                    end
                end
                S_AR_LSU: begin
                    if (!lsu_arvalid) begin
                        state <= S_IDLE;
                    end else if (m_arready) begin
                        state <= S_R_LSU;
                    end
                end
                S_R_IFU: begin
                    if (r_last_hs) begin
                        state <= S_IDLE;
                    end
                end
                S_R_LSU: begin
                    if (r_last_hs) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and payload steering selected by state only; a requester
    // that is not granted never sees bus activity.
    always_comb begin
        m_arvalid   = 1'b0;
        m_ar        = '0;
        m_rready    = 1'b0;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        case (state)
            S_AR_IFU: begin
                m_arvalid   = ifu_arvalid;
                m_ar        = ifu_ar;
                ifu_arready = m_arready;
            end
            S_AR_LSU: begin
                m_arvalid   = lsu_arvalid;
                m_ar        = lsu_ar;
                lsu_arready = m_arready;
            end
            S_R_IFU: begin
                m_rready   = ifu_rready;
                ifu_rvalid = m_rvalid;
            end
            S_R_LSU: begin
                m_rready   = lsu_rready;
                lsu_rvalid = m_rvalid;
            end
            default: begin
                m_arvalid = 1'b0;
            end
        endcase
    end

`ifdef YSYX_24100006_ARB_PERF_EN
    // Wait-cycle counters: request pending but not yet accepted; wrap freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ifu_wait <= 32'd0;
            perf_lsu_wait <= 32'd0;
        end else begin
            if (ifu_arvalid && !ifu_arready) begin
                perf_ifu_wait <= perf_ifu_wait + 32'd1;
            end
            if (lsu_arvalid && !lsu_arready) begin
                perf_lsu_wait <= perf_lsu_wait + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
